// File: rtl/result_drain_unit.sv
// result_drain_unit
//   Snapshots the matrixSize x matrixSize MAC accumulators on the computeDone
//   pulse, then streams them out one row per beat over a valid/ready
//   interface. The MAC array is free again as soon as the snapshot is taken.
//   Optional macro OUT_SATURATE_EN: output elements are signed-saturated from
//   accSize down to dataSize bits at capture time. When it is undefined, the
//   elements pass through at accSize bits.
module result_drain_unit #(
    parameter int matrixSize = 8,
    parameter int dataSize   = 16,
    parameter int accSize    = 32,
`ifdef OUT_SATURATE_EN
    localparam int OUT_W     = dataSize,
`else
    localparam int OUT_W     = accSize,
`endif
    localparam int ROW_W     = $clog2(matrixSize)
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              computeDone,
    input  logic [matrixSize-1:0][matrixSize-1:0][accSize-1:0] accIn,
    output logic                                              outValid,
    input  logic                                              outReady,
    output logic [matrixSize-1:0][OUT_W-1:0]                  outData,
    output logic [ROW_W-1:0]                                  outRowIndex,
    output logic                                              outLast,
    output logic                                              busy,
    output logic                                              overrunError,
    input  logic                                              clearError
);

    typedef enum logic {
        st_idle,
        st_drain
    } state_t;

    state_t state, state_next;

    logic [matrixSize-1:0][matrixSize-1:0][OUT_W-1:0] snap;
    logic [ROW_W-1:0] row;

    logic transfer;
    logic last_row;
    logic capture;
    logic overrun;

    // Convert one accumulator to the output element format.
    function automatic logic [OUT_W-1:0] shape(input logic [accSize-1:0] v);
`ifdef OUT_SATURATE_EN
        logic signed [accSize-1:0] sat_max;
        logic signed [accSize-1:0] sat_min;
        sat_max = {{(accSize-dataSize+1){1'b0}}, {(dataSize-1){1'b1}}};
        sat_min = {{(accSize-dataSize+1){1'b1}}, {(dataSize-1){1'b0}}};
        if ($signed(v) > sat_max)
            shape = sat_max[OUT_W-1:0];
        else if ($signed(v) < sat_min)
            shape = sat_min[OUT_W-1:0];
        else
            shape = v[OUT_W-1:0];
`else
        shape = v;
`endif
    endfunction

    assign transfer = outValid && outReady;
    assign last_row = (row == ROW_W'(matrixSize - 1));
    // A new pass is accepted when idle, or exactly as the last row leaves.
    assign capture  = computeDone && ((state == st_idle) || (transfer && last_row));
    assign overrun  = computeDone && (state == st_drain) && !(transfer && last_row);

    // State register.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= st_idle;
        else
            state <= state_next;
    end

    // Next-state logic: enter DRAIN on capture, leave after the last row
    // unless a back-to-back pass is captured on that same cycle.
    // NOTE: state_next gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            st_idle:  if (capture) state_next = st_drain;
            st_drain: if (transfer && last_row && !capture) state_next = st_idle;
            default:  state_next = st_idle;
        endcase
    end

    // Output decode: everything driven from registered state, no path from accIn.
    always_comb begin
        outValid    = (state == st_drain);
        busy        = (state == st_drain);
        outLast     = (state == st_drain) && last_row;
        outRowIndex = row;
        outData     = snap[row];
    end

    // Row counter: restarts on capture, advances on each accepted beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            row <= '0;
        else if (capture)
            row <= '0;
        else if (transfer)
            row <= last_row ? '0 : row + 1'b1;
    end

    // Snapshot of the accumulator array, taken on the accepted computeDone.
    // NOTE: this storage is reset on purpose so outData reads zero out of reset;
    // plain data arrays are normally left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap <= '0;
        end else if (capture) begin
            for (int r = 0; r < matrixSize; r++)
                for (int c = 0; c < matrixSize; c++)
                    snap[r][c] <= shape(accIn[r][c]);
        end
    end

    // Sticky overrun flag; a new overrun wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overrunError <= 1'b0;
        else if (overrun)
            overrunError <= 1'b1;
        else if (clearError)
            overrunError <= 1'b0;
    end

endmodule
